// File: rtl/key_matrix_scan.sv
// key_matrix_scan: 4x4 active-low keypad scanner. Walks a low strobe across the columns,
// debounces a press on the row lines and reports one key code with a one-cycle valid pulse.
// Optional feature: define KEY_REPEAT_EN to re-pulse key_valid every REPEAT_MAX+1 cycles
// while a key stays held.
module key_matrix_scan #(
  parameter logic [15:0] SCAN_CNT_MAX = 16'd49_999,
  parameter logic [19:0] DEBOUNCE_MAX = 20'd999_999,
  parameter logic [25:0] REPEAT_MAX   = 26'd24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  typedef enum logic [1:0] {StScan, StDebounce, StHeld, StRelease} state_e;

  state_e      state_q, state_d;
  logic [3:0]  row_meta_q, row_s_q;
  logic [1:0]  col_q, col_d;
  logic [15:0] scan_cnt_q, scan_cnt_d;
  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  code_q, code_d;
  logic        valid_q, valid_d;
  logic        pressed_q, pressed_d;
  logic [1:0]  row_idx;
  logic        rows_idle;

`ifdef KEY_REPEAT_EN
  logic [25:0] rep_cnt_q, rep_cnt_d;
`else
  // Auto-repeat is compiled out, so the period parameter has no consumer.
  logic unused_repeat_max;
  assign unused_repeat_max = ^REPEAT_MAX;
`endif

  assign rows_idle = (row_s_q == 4'hF);

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      row_meta_q <= 4'hF;
      row_s_q    <= 4'hF;
    end else begin
      row_meta_q <= row_in;
      row_s_q    <= row_meta_q;
    end
  end

  // Fixed priority: the lowest-index low row in the captured pattern wins
  always_comb begin
    row_idx = 2'd3;
    if (!pat_q[0]) begin
      row_idx = 2'd0;
    end else if (!pat_q[1]) begin
      row_idx = 2'd1;
    end else if (!pat_q[2]) begin
      row_idx = 2'd2;
    end
  end

  // Next-state and counter logic for the scan/debounce/held/release FSM
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    pat_d      = pat_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    pressed_d  = pressed_q;
`ifdef KEY_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    case (state_q)
      StScan: begin
        if (scan_cnt_q == SCAN_CNT_MAX) begin
          scan_cnt_d = '0;
          if (rows_idle) begin
            col_d = col_q + 2'd1;
          end else begin
            pat_d     = row_s_q;
            deb_cnt_d = '0;
            state_d   = StDebounce;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 16'd1;
        end
      end
      StDebounce: begin
        if (row_s_q != pat_q) begin
          scan_cnt_d = '0;
          state_d    = StScan;
        end else if (deb_cnt_q == DEBOUNCE_MAX) begin
          code_d    = {row_idx, col_q};
          valid_d   = 1'b1;
          pressed_d = 1'b1;
          deb_cnt_d = '0;
          state_d   = StHeld;
`ifdef KEY_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          deb_cnt_d = deb_cnt_q + 20'd1;
        end
      end
      StHeld: begin
        if (rows_idle) begin
          deb_cnt_d = '0;
          state_d   = StRelease;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_cnt_q == REPEAT_MAX) begin
          valid_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 26'd1;
        end
`endif
      end
      StRelease: begin
        if (!rows_idle) begin
          // Release bounce: back to held without a new report
          deb_cnt_d = '0;
          state_d   = StHeld;
`ifdef KEY_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else if (deb_cnt_q == DEBOUNCE_MAX) begin
          pressed_d  = 1'b0;
          col_d      = col_q + 2'd1;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
          state_d    = StScan;
        end else begin
          deb_cnt_d = deb_cnt_q + 20'd1;
        end
      end
      default: state_d = StScan;
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StScan;
      col_q      <= 2'd0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      pat_q      <= 4'hF;
      code_q     <= 4'h0;
      valid_q    <= 1'b0;
      pressed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      pat_q      <= pat_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      pressed_q  <= pressed_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat period counter, only advanced while held
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  // One column strobed low at a time
  always_comb begin
    col_out = 4'b1110;
    unique case (col_q)
      2'd0: col_out = 4'b1110;
      2'd1: col_out = 4'b1101;
      2'd2: col_out = 4'b1011;
      2'd3: col_out = 4'b0111;
    endcase
  end

  assign key_valid   = valid_q;
  assign key_code    = code_q;
  assign key_pressed = pressed_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Testbench for key_matrix_scan: keypad model, cycle-level reference model, vector table,
// hand-written corner sequences and a randomized phase.
module tb_key_matrix_scan;

  localparam int ScanMax = 3;
  localparam int DebMax  = 7;
  localparam int RepMax  = 15;
  localparam int PhScan  = 0;
  localparam int PhDeb   = 1;
  localparam int PhHeld  = 2;
  localparam int PhRel   = 3;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_pressed;

  key_matrix_scan #(
    .SCAN_CNT_MAX(16'd3),
    .DEBOUNCE_MAX(20'd7),
    .REPEAT_MAX  (26'd15)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_pressed(key_pressed)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_cmp;
  int          n_fail;
  int          cyc;
  int          dut_pulses;
  int          mdl_pulses;
  int          pulse_cyc[$];
  logic [15:0] keys;

  // Reference model state
  logic [3:0] m_sync[$];
  int         m_phase, m_col, m_dwell, m_stable, m_rep;
  logic [3:0] m_pat, m_code;
  logic       m_valid, m_pressed;

  typedef struct {
    int         row;
    int         col;
    int         hold;
    logic [3:0] code;
    int         pulses;
    int         pulses_rep;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic note_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic int row_of(input logic [3:0] p);
    int idx = 3;
    for (int r = 3; r >= 0; r--) if (p[r] == 1'b0) idx = r;
    return idx;
  endfunction

  function automatic logic [15:0] kb(input int r, input int c);
    logic [15:0] b;
    b = 16'd1;
    return b << (r * 4 + c);
  endfunction

  // Physical keypad: a row reads low when a pressed key joins it to the strobed column
  function automatic logic [3:0] pad_rows(input logic [15:0] k, input int c);
    logic [3:0] r = 4'hF;
    for (int i = 0; i < 4; i++) if (k[i * 4 + c]) r[i] = 1'b0;
    return r;
  endfunction

  function automatic logic [3:0] exp_col();
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << m_col);
  endfunction

  task automatic model_tick(input logic [3:0] rin, input logic rst);
    logic [3:0] rs;
    if (rst) begin
      m_sync    = '{4'hF, 4'hF};
      m_phase   = PhScan;
      m_col     = 0;
      m_dwell   = 0;
      m_stable  = 0;
      m_rep     = 0;
      m_pat     = 4'hF;
      m_code    = 4'h0;
      m_valid   = 1'b0;
      m_pressed = 1'b0;
      return;
    end
    rs      = m_sync[0];
    m_valid = 1'b0;
    case (m_phase)
      PhScan: begin
        if (m_dwell == ScanMax) begin
          m_dwell = 0;
          if (rs == 4'hF) begin
            m_col = (m_col + 1) % 4;
          end else begin
            m_pat    = rs;
            m_stable = 0;
            m_phase  = PhDeb;
          end
        end else begin
          m_dwell++;
        end
      end
      PhDeb: begin
        if (rs != m_pat) begin
          m_phase = PhScan;
          m_dwell = 0;
        end else if (m_stable == DebMax) begin
          m_phase   = PhHeld;
          m_code    = 4'(row_of(m_pat) * 4 + m_col);
          m_valid   = 1'b1;
          m_pressed = 1'b1;
          m_rep     = 0;
        end else begin
          m_stable++;
        end
      end
      PhHeld: begin
        if (rs == 4'hF) begin
          m_stable = 0;
          m_phase  = PhRel;
        end else begin
`ifdef KEY_REPEAT_EN
          if (m_rep == RepMax) begin
            m_valid = 1'b1;
            m_rep   = 0;
          end else begin
            m_rep++;
          end
`endif
        end
      end
      default: begin
        if (rs != 4'hF) begin
          m_phase = PhHeld;
          m_rep   = 0;
        end else if (m_stable == DebMax) begin
          m_pressed = 1'b0;
          m_col     = (m_col + 1) % 4;
          m_dwell   = 0;
          m_phase   = PhScan;
        end else begin
          m_stable++;
        end
      end
    endcase
    void'(m_sync.pop_front());
    m_sync.push_back(rin);
  endtask

  // One clock: advance the model, compare all outputs, refresh the keypad rows
  task automatic step();
    logic [9:0] exp_v, act_v;
    @(posedge sys_clk);
    model_tick(row_in, sys_rst);
    #1;
    cyc++;
    exp_v = {exp_col(), m_valid, m_code, m_pressed};
    act_v = {col_out, key_valid, key_code, key_pressed};
    check("cycle", 32'(act_v), 32'(exp_v));
    if (key_valid === 1'b1) begin
      dut_pulses++;
      pulse_cyc.push_back(cyc);
    end
    if (m_valid) mdl_pulses++;
    row_in = pad_rows(keys, m_col);
  endtask

  task automatic set_keys(input logic [15:0] k);
    keys   = k;
    row_in = pad_rows(keys, m_col);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    set_keys('0);
    step();
    step();
    sys_rst = 1'b0;
  endtask

  task automatic clear_counts();
    dut_pulses = 0;
    mdl_pulses = 0;
    pulse_cyc.delete();
  endtask

  task automatic wait_pulse(input string name, input int limit);
    int n = 0;
    while (key_valid !== 1'b1 && n < limit) begin
      step();
      n++;
    end
    if (key_valid !== 1'b1) note_timeout(name);
  endtask

  task automatic check_pulses(input string name, input int exp_default);
`ifdef KEY_REPEAT_EN
    check(name, dut_pulses, mdl_pulses);
`else
    check(name, dut_pulses, exp_default);
`endif
  endtask

  initial begin
    logic [3:0] idle_seq[4];
    int         n;
    int         hold_left;
    int         first;

    n_cmp   = 0;
    n_fail  = 0;
    cyc     = 0;
    keys    = '0;
    row_in  = 4'hF;
    sys_rst = 1'b1;
    model_tick(4'hF, 1'b1);
    clear_counts();

    vecs[0] = '{2, 1, 100, 4'h9, 1, 6};
    vecs[1] = '{0, 0, 30, 4'h0, 1, 2};
    vecs[2] = '{3, 3, 40, 4'hF, 1, 2};
    vecs[3] = '{1, 2, 20, 4'h6, 1, 1};
    vecs[4] = '{2, 0, 10, 4'h8, 1, 1};
    vecs[5] = '{2, 0, 9, 4'h0, 0, 0};

    // Reset values and idle sweep
    do_reset();
    check("rst_col", col_out, 4'b1110);
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    check("rst_pressed", key_pressed, 1'b0);
    idle_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    clear_counts();
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i % 4 == 0) check($sformatf("idle_col%0d", i / 4), col_out, idle_seq[i / 4 - 1]);
    end
    check("idle_no_pulse", dut_pulses, 0);

    // Single-key vectors, each from a fresh reset
    for (int i = 0; i < 6; i++) begin
      do_reset();
      clear_counts();
      set_keys(kb(vecs[i].row, vecs[i].col));
      repeat (vecs[i].hold) step();
      set_keys('0);
      repeat (40) step();
`ifdef KEY_REPEAT_EN
      check($sformatf("vec%0d_pulses", i), dut_pulses, vecs[i].pulses_rep);
`else
      check($sformatf("vec%0d_pulses", i), dut_pulses, vecs[i].pulses);
`endif
      check($sformatf("vec%0d_code", i), key_code, vecs[i].code);
      check($sformatf("vec%0d_released", i), key_pressed, 1'b0);
    end

    // Press bounce: toggle every 3 cycles, then hold steady
    do_reset();
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      set_keys(((i / 3) % 2 == 0) ? kb(1, 0) : 16'h0);
      step();
    end
    check("bounce_no_pulse", dut_pulses, 0);
    set_keys(kb(1, 0));
    repeat (30) step();
    check_pulses("bounce_pulses", 1);
    check("bounce_code", key_code, 4'h4);
    set_keys('0);
    repeat (30) step();

    // Release bounce: short low glitch while releasing
    do_reset();
    clear_counts();
    set_keys(kb(0, 2));
    wait_pulse("relb_pulse", 40);
    repeat (3) step();
    set_keys('0);
    repeat (5) step();
    set_keys(kb(0, 2));
    repeat (2) step();
    set_keys('0);
    repeat (5) step();
    check("relb_still_pressed", key_pressed, 1'b1);
    repeat (30) step();
    check_pulses("relb_pulses", 1);
    check("relb_released", key_pressed, 1'b0);

    // Two rows low on column 0, then a third key added while held
    do_reset();
    clear_counts();
    set_keys(kb(1, 0) | kb(3, 0));
    wait_pulse("multi_pulse", 40);
    check("multi_code", key_code, 4'h4);
    set_keys(kb(1, 0) | kb(3, 0) | kb(0, 0));
    repeat (12) step();
    check("multi_code_held", key_code, 4'h4);
    check_pulses("multi_pulses", 1);
    set_keys('0);
    repeat (40) step();

    // Reset asserted during debounce
    set_keys(kb(0, 1));
    n = 0;
    while (m_phase != PhDeb && n < 40) begin
      step();
      n++;
    end
    if (m_phase != PhDeb) note_timeout("reach_debounce");
    repeat (2) step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check("mid_rst_col", col_out, 4'b1110);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_pressed", key_pressed, 1'b0);
    repeat (40) step();
    set_keys('0);
    repeat (40) step();

`ifdef KEY_REPEAT_EN
    // Auto-repeat timing relative to the first pulse
    do_reset();
    clear_counts();
    set_keys(kb(2, 2));
    wait_pulse("rep_first", 40);
    first = cyc;
    pulse_cyc.delete();
    repeat (60) step();
    set_keys('0);
    repeat (30) step();
    check("rep_count", pulse_cyc.size(), 3);
    for (int i = 0; i < 3 && i < pulse_cyc.size(); i++)
      check($sformatf("rep_offset%0d", i), pulse_cyc[i] - first, 16 * (i + 1));
`else
    first = 0;
`endif

    // Randomized presses, releases, bounces and occasional resets
    do_reset();
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        case ($urandom_range(0, 3))
          0: set_keys('0);
          1: set_keys(kb($urandom_range(0, 3), $urandom_range(0, 3)));
          2: set_keys(keys ^ kb($urandom_range(0, 3), $urandom_range(0, 3)));
          default: set_keys(16'($urandom_range(0, 65535)) & 16'($urandom_range(0, 65535)));
        endcase
        hold_left = $urandom_range(1, 60);
      end
      hold_left--;
      if ($urandom_range(0, 999) == 0) sys_rst = 1'b1;
      step();
      sys_rst = 1'b0;
    end
    set_keys('0);
    repeat (60) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
